// File: rtl/seq_sort_n.sv
// Streaming group sorter: collects N unsigned samples with insertion on arrival,
// then drains them in sorted order under a valid/ready handshake.
module seq_sort_n #(
    parameter int unsigned DW = 3,
    parameter int unsigned N  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] inp,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          desc,
    output logic [DW-1:0] outp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          ord_q, ord_d;
    logic [DW-1:0] sbuf_q [N];
    logic [DW-1:0] sbuf_d [N];
    logic [DW-1:0] outp_q, outp_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          out_last_q, out_last_d;

    logic          ord_c;
    logic          accept_c;
    logic [N-1:0]  aft_c;
    logic [DW-1:0] ins_c [N];

    // Insertion network: entries that sort after inp move up one slot.
    always_comb begin
        ord_c    = (cnt_q == '0) ? desc : ord_q;
        accept_c = in_valid & in_ready_q;
        for (int i = 0; i < N; i++) begin
            aft_c[i] = ord_c ? (sbuf_q[i] < inp) : (sbuf_q[i] > inp);
        end
        ins_c[0] = ((cnt_q != '0) && !aft_c[0]) ? sbuf_q[0] : inp;
        for (int i = 1; i < N; i++) begin
            if (CW'(i) > cnt_q) begin
                ins_c[i] = sbuf_q[i];
            end else if ((CW'(i) < cnt_q) && !aft_c[i]) begin
                ins_c[i] = sbuf_q[i];
            end else if (aft_c[i-1]) begin
                ins_c[i] = sbuf_q[i-1];
            end else begin
                ins_c[i] = inp;
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        ord_d       = ord_q;
        sbuf_d      = sbuf_q;
        outp_d      = outp_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        out_last_d  = out_last_q;
        case (state_q)
            FILL: begin
                if (accept_c) begin
                    sbuf_d = ins_c;
                    if (cnt_q == '0) begin
                        ord_d = desc;
                    end
                    if (cnt_q == CW'(N - 1)) begin
                        state_d     = DRAIN;
                        cnt_d       = '0;
                        idx_d       = '0;
                        outp_d      = ins_c[0];
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (idx_q == CW'(N - 1)) begin
                        state_d     = FILL;
                        idx_d       = '0;
                        cnt_d       = '0;
                        outp_d      = '0;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        out_last_d  = 1'b0;
                    end else begin
                        idx_d      = idx_q + CW'(1);
                        outp_d     = sbuf_q[idx_d];
                        out_last_d = (idx_d == CW'(N - 1));
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            idx_q       <= '0;
            ord_q       <= 1'b0;
            outp_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_last_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                sbuf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            ord_q       <= ord_d;
            outp_q      <= outp_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            out_last_q  <= out_last_d;
            sbuf_q      <= sbuf_d;
        end
    end

    assign outp      = outp_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_seq_sort_n.sv
// Bench for seq_sort_n: table of groups plus hand-written sequences for
// backpressure, bubbles and reset; outputs checked against a scoreboard queue.
module tb_seq_sort_n;

    localparam int unsigned DW = 3;
    localparam int unsigned N  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] inp;
    logic          in_valid;
    logic          in_ready;
    logic          desc;
    logic [DW-1:0] outp;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    always #5 clk = ~clk;

    seq_sort_n #(.DW(DW), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .inp      (inp),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .desc     (desc),
        .outp     (outp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last)
    );

    typedef struct packed {
        logic [DW-1:0] val;
        logic          last;
    } exp_t;

    typedef struct {
        logic [DW-1:0] smp [N];
        bit            d;
        logic [DW-1:0] exp [N];
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int k, input int a, input int b, input int c, input int e,
                           input bit d, input int x0, input int x1, input int x2, input int x3);
        tbl[k].smp[0] = DW'(a);
        tbl[k].smp[1] = DW'(b);
        tbl[k].smp[2] = DW'(c);
        tbl[k].smp[3] = DW'(e);
        tbl[k].d      = d;
        tbl[k].exp[0] = DW'(x0);
        tbl[k].exp[1] = DW'(x1);
        tbl[k].exp[2] = DW'(x2);
        tbl[k].exp[3] = DW'(x3);
    endtask

    task automatic push_exp(input int v, input bit last);
        exp_t e;
        e.val  = DW'(v);
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic send(input logic [DW-1:0] v, input bit d);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at %0d, required 1", in_ready);
        end
        in_valid = 1'b1;
        inp      = v;
        desc     = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drive_cycle(input bit v, input int s, input bit d);
        in_valid = v;
        inp      = DW'(s);
        desc     = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_queue_empty", sb.size(), 0);
        chk("drain_out_valid_low", int'(out_valid), 0);
    endtask

    // Scoreboard monitor: a handshake at the coming edge pops one expected value.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d with nothing expected", outp);
            end else begin
                e = sb.pop_front();
                chk("outp", int'(outp), int'(e.val));
                chk("out_last", int'(out_last), int'(e.last));
                chk("in_ready_in_drain", int'(in_ready), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] s [N];
        logic [DW-1:0] t;
        bit            rd;
        int            j;

        rst       = 1'b1;
        in_valid  = 1'b0;
        inp       = '0;
        desc      = 1'b0;
        out_ready = 1'b1;

        set_vec(0, 5, 2, 7, 2, 1'b0, 2, 2, 5, 7);
        set_vec(1, 5, 2, 7, 2, 1'b1, 7, 5, 2, 2);
        set_vec(2, 1, 3, 0, 6, 1'b0, 0, 1, 3, 6);
        set_vec(3, 7, 6, 5, 4, 1'b0, 4, 5, 6, 7);
        set_vec(4, 3, 2, 1, 0, 1'b0, 0, 1, 2, 3);
        set_vec(5, 7, 7, 7, 7, 1'b0, 7, 7, 7, 7);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_outp", int'(outp), 0);
        chk("reset_out_last", int'(out_last), 0);

        // Table groups streamed back to back
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) push_exp(int'(tbl[k].exp[i]), i == N - 1);
            for (int i = 0; i < N; i++) begin
                send(tbl[k].smp[i], tbl[k].d);
                if (k == 0 && i == N - 2) chk("no_early_valid", int'(out_valid), 0);
            end
            if (k == 0) begin
                for (int c = 0; c <= N; c++) begin
                    chk("valid_window", int'(out_valid), (c < N) ? 1 : 0);
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_drain();

        // Backpressure: out_ready alternates while draining
        for (int i = 0; i < N; i++) push_exp(int'(tbl[0].exp[i]), i == N - 1);
        for (int i = 0; i < N; i++) send(tbl[0].smp[i], 1'b0);
        for (int c = 0; c < 12; c++) begin
            out_ready = (c % 2 == 0);
            if (out_valid) chk("bp_in_ready_low", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_drain();

        // Bubbles, desc toggled after the first accept
        push_exp(1, 1'b0);
        push_exp(3, 1'b0);
        push_exp(4, 1'b0);
        push_exp(6, 1'b1);
        drive_cycle(1'b1, 4, 1'b0);
        drive_cycle(1'b0, 5, 1'b1);
        drive_cycle(1'b1, 1, 1'b1);
        drive_cycle(1'b0, 7, 1'b1);
        drive_cycle(1'b0, 0, 1'b1);
        drive_cycle(1'b1, 6, 1'b1);
        drive_cycle(1'b1, 3, 1'b1);
        desc = 1'b0;
        wait_drain();

        // Reset after two accepts discards the partial group
        send(3'd7, 1'b0);
        send(3'd6, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) push_exp(i, i == N - 1);
        send(3'd1, 1'b0);
        send(3'd0, 1'b0);
        send(3'd3, 1'b0);
        send(3'd2, 1'b0);
        wait_drain();

        // Reset during drain after one output
        push_exp(2, 1'b0);
        for (int i = 0; i < N; i++) send(tbl[0].smp[i], 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_drain_out_valid", int'(out_valid), 0);
        chk("rst_drain_in_ready", int'(in_ready), 1);
        chk("rst_drain_out_last", int'(out_last), 0);
        chk("rst_drain_outp", int'(outp), 0);
        rst = 1'b0;
        chk("rst_drain_queue", sb.size(), 0);

        // Random groups against a reference sort
        for (int g = 0; g < 6; g++) begin
            rd = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) s[i] = DW'($urandom_range(0, (1 << DW) - 1));
            for (int i = 0; i < N; i++) send(s[i], rd);
            for (int i = 1; i < N; i++) begin
                j = i;
                while (j > 0 && (rd ? (s[j-1] < s[j]) : (s[j-1] > s[j]))) begin
                    t      = s[j];
                    s[j]   = s[j-1];
                    s[j-1] = t;
                    j--;
                end
            end
            for (int i = 0; i < N; i++) push_exp(int'(s[i]), i == N - 1);
            wait_drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
